// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// The divider produces one quotient bit per cycle and returns {remainder, quotient}.
module div #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        END
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(DATA_W);

    state_t                state, state_nxt;
    logic [5:0]            cnt, cnt_nxt;
    logic [2*DATA_W:0]     dividend, dividend_nxt;
    logic [DATA_W-1:0]     divisor, divisor_nxt;
    logic                  signed_q, signed_nxt;
    logic                  sign1_q, sign1_nxt;
    logic                  sign2_q, sign2_nxt;
    logic [2*DATA_W-1:0]   result_nxt;
    logic                  ready_nxt;

    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     abs1, abs2;
    logic [DATA_W-1:0]     quot, rem;

    // State and datapath registers; reset clears everything, including an in-flight division
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dividend <= dividend_nxt;
            divisor  <= divisor_nxt;
            signed_q <= signed_nxt;
            sign1_q  <= sign1_nxt;
            sign2_q  <= sign2_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    // Next-state logic, operand latching, restoring iteration and result fix-up
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        signed_nxt   = signed_q;
        sign1_nxt    = sign1_q;
        sign2_nxt    = sign2_q;
        result_nxt   = result_o;
        ready_nxt    = ready_o;

        abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        diff = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

        quot = dividend[DATA_W-1:0];
        rem  = dividend[2*DATA_W:DATA_W+1];
        if (signed_q && (sign1_q ^ sign2_q)) quot = -quot;
        if (signed_q && sign1_q)             rem  = -rem;

        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_nxt = BYZERO;
                    end else begin
                        state_nxt    = ON;
                        cnt_nxt      = '0;
                        dividend_nxt = {{DATA_W{1'b0}}, abs1, 1'b0};
                        divisor_nxt  = abs2;
                        signed_nxt   = signed_div_i;
                        sign1_nxt    = opdata1_i[DATA_W-1];
                        sign2_nxt    = opdata2_i[DATA_W-1];
                    end
                end
            end
            BYZERO: begin
                state_nxt  = END;
                result_nxt = '0;
                ready_nxt  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else if (cnt != LAST_CNT) begin
                    if (diff[DATA_W])
                        dividend_nxt = dividend << 1;
                    else
                        dividend_nxt = {diff[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                    cnt_nxt = cnt + 6'd1;
                end else begin
                    result_nxt = {rem, quot};
                    ready_nxt  = 1'b1;
                    state_nxt  = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nxt  = IDLE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
